// File: rtl/rah_app_packer_if.sv
// rah_app_packer_if: user payload stream plus encoder write-FIFO lane for one app slot.
interface rah_app_packer_if #(
   parameter int DATA_WIDTH = 48
);
   logic                  in_valid;
   logic [DATA_WIDTH-1:0] in_data;
   logic                  in_last;
   logic                  in_ready;
   logic                  wr_prog_fifo_full;
   logic                  wr_fifo_full;
   logic                  wr_en;
   logic [DATA_WIDTH-1:0] wr_data;
   logic                  send_data;
   logic                  busy;
   logic                  overflow;
   modport master (
      output in_valid, in_data, in_last, wr_prog_fifo_full, wr_fifo_full,
      input  in_ready, wr_en, wr_data, send_data, busy, overflow
   );
   modport slave (
      input  in_valid, in_data, in_last, wr_prog_fifo_full, wr_fifo_full,
      output in_ready, wr_en, wr_data, send_data, busy, overflow
   );
endinterface

// File: rtl/rah_app_packer.sv
// rah_app_packer: buffers one payload burst, writes header + burst into the encoder FIFO, then pulses send_data.
module rah_app_packer #(
   parameter int DATA_WIDTH = 48,
   parameter int APP_ID     = 0,
   parameter int MAX_BURST  = 256,
   parameter int TIMEOUT    = 1024
) (
   input logic            clk,
   input logic            rst,
   rah_app_packer_if.slave bus
);
   localparam int AW = (MAX_BURST > 1) ? $clog2(MAX_BURST) : 1;
   localparam int CW = $clog2(MAX_BURST) + 1;
   localparam int IW = $clog2(TIMEOUT + 1) + 1;
   typedef enum logic [2:0] {IDLE, FILL, HDR, DRAIN, SEND} state_t;
   state_t                state;
   logic [DATA_WIDTH-1:0] mem [MAX_BURST];
   logic [CW-1:0]         count;
   logic [CW-1:0]         rd_ptr;
   logic [IW-1:0]         idle;
   logic [7:0]            seq;
   logic                  acc;
   logic                  close;
   logic                  try_wr;
   logic                  issue;
   assign bus.in_ready = !rst && (state == IDLE || (state == FILL && count < CW'(MAX_BURST)));
   assign bus.busy     = state != IDLE;
   assign acc          = bus.in_valid && bus.in_ready;
   assign close        = bus.in_last || (count + 1'b1 == CW'(MAX_BURST));
   assign try_wr       = !bus.wr_prog_fifo_full && (state == HDR || (state == DRAIN && rd_ptr != count));
   assign issue        = try_wr && !bus.wr_fifo_full;
   always_ff @(posedge clk)
      if (acc) mem[count[AW-1:0]] <= bus.in_data;
   always_ff @(posedge clk) begin
      if (rst) begin
         state         <= IDLE;
         count         <= '0;
         rd_ptr        <= '0;
         idle          <= '0;
         seq           <= '0;
         bus.wr_en     <= 1'b0;
         bus.wr_data   <= '0;
         bus.send_data <= 1'b0;
         bus.overflow  <= 1'b0;
      end else begin
         bus.wr_en     <= issue;
         bus.send_data <= 1'b0;
         if (try_wr && bus.wr_fifo_full) bus.overflow <= 1'b1;
         case (state)
            IDLE, FILL: begin
               if (acc) begin
                  count <= count + 1'b1;
                  idle  <= '0;
                  state <= close ? HDR : FILL;
               end else if (state == FILL && TIMEOUT != 0) begin
                  idle <= idle + 1'b1;
                  if (idle + 1'b1 == IW'(TIMEOUT)) state <= HDR;
               end
            end
            HDR: if (issue) begin
               bus.wr_data <= DATA_WIDTH'({8'hA5, 8'(APP_ID), seq, 16'(count)});
               rd_ptr      <= '0;
               state       <= DRAIN;
            end
            DRAIN: begin
               if (rd_ptr == count) begin
                  bus.send_data <= 1'b1;
                  state         <= SEND;
               end else if (issue) begin
                  bus.wr_data <= mem[rd_ptr[AW-1:0]];
                  rd_ptr      <= rd_ptr + 1'b1;
               end
            end
            SEND: begin
               seq   <= seq + 1'b1;
               count <= '0;
               state <= IDLE;
            end
            default: state <= IDLE;
         endcase
      end
   end
endmodule
